// File: rtl/load_store_unit.sv
// load_store_unit: issues one req/ack data-memory access per request and returns the extended load result.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
//   state | meaning
//   IDLE  | waiting for dMemRead/dMemWrite
//   REQ   | memReq asserted, waiting for memAck or timeout
//   DONE  | one-cycle lsuDone pulse with lsuErr
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dMemRead,
  input  logic            dMemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWdata,
  output logic [3:0]      memBe,
  input  logic            memAck,
  input  logic [XLEN-1:0] memRdata,
  output logic [XLEN-1:0] loadData,
  output logic            lsuBusy,
  output logic            lsuDone,
  output logic [1:0]      lsuErr
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsuState_t;
  lsuState_t state, stateNext;

  logic [2:0]      f3Q;
  logic [1:0]      offQ;
  logic [CW-1:0]   waitCnt;
  logic [1:0]      errQ, errNext;
  logic            acceptReq, captureLoad, errLoad;
  logic            isByte, isHalf, misaligned, timeoutHit;
  logic [7:0]      rdByte;
  logic [15:0]     rdHalf;
  logic [XLEN-1:0] rdExt;

  // Stores only know 000/001 as narrow sizes; loads also accept the unsigned 1xx variants.
  always_comb begin
    isByte = dMemWrite ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
    isHalf = dMemWrite ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = isHalf ? addr[0] : (!isByte && (addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    rdByte = memRdata[{offQ, 3'b000} +: 8];
    rdHalf = offQ[1] ? memRdata[31:16] : memRdata[15:0];
    case (f3Q[1:0])
      2'b00:   rdExt = {{(XLEN-8){rdByte[7] & ~f3Q[2]}}, rdByte};
      2'b01:   rdExt = {{(XLEN-16){rdHalf[15] & ~f3Q[2]}}, rdHalf};
      default: rdExt = memRdata;
    endcase
  end

  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (waitCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    acceptReq   = 1'b0;
    captureLoad = 1'b0;
    errLoad     = 1'b0;
    errNext     = 2'b00;
    case (state)
      IDLE: begin
        if (dMemWrite || dMemRead) begin
          errLoad = 1'b1;
          if (misaligned) begin
            errNext   = 2'b10;
            stateNext = DONE;
          end else begin
            acceptReq = 1'b1;
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        if (memAck) begin
          captureLoad = !memWe;
          errLoad     = 1'b1;
          stateNext   = DONE;
        end else if (timeoutHit) begin
          errNext   = 2'b01;
          errLoad   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign memReq  = (state == REQ);
  assign lsuBusy = (state != IDLE);
  assign lsuDone = (state == DONE);
  assign lsuErr  = lsuDone ? errQ : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memBe    <= 4'b0000;
      f3Q      <= 3'b000;
      offQ     <= 2'b00;
      errQ     <= 2'b00;
      loadData <= '0;
      waitCnt  <= '0;
    end else begin
      if (acceptReq) begin
        memWe   <= dMemWrite;
        memAddr <= {addr[XLEN-1:2], 2'b00};
        f3Q     <= funct3;
        offQ    <= addr[1:0];
        if (!dMemWrite) begin
          memBe    <= 4'b1111;
          memWdata <= '0;
        end else if (isByte) begin
          memBe    <= 4'b0001 << addr[1:0];
          memWdata <= {4{storeData[7:0]}};
        end else if (isHalf) begin
          memBe    <= addr[1] ? 4'b1100 : 4'b0011;
          memWdata <= {2{storeData[15:0]}};
        end else begin
          memBe    <= 4'b1111;
          memWdata <= storeData;
        end
      end
      if (errLoad)     errQ     <= errNext;
      if (captureLoad) loadData <= rdExt;
      if ((state == REQ) && !memAck) waitCnt <= waitCnt + 1'b1;
      else                           waitCnt <= '0;
    end
  end

endmodule
